// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding and load-use bubble insertion.
// Optional perf counters enabled by defining IDEX_PERF_CNT_EN.
module id_ex_operand_stage #(
  parameter int XLEN = 64,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [2:0]      id_alu_control,
  input  logic            id_alu_src,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            id_mem_to_reg,
  input  logic            id_branch,
  input  logic            exm_reg_write,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_reg_write,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_result,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      ex_alu_control,
  output logic [XLEN-1:0] ex_store_data,
  output logic [RA_W-1:0] ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic            ex_mem_to_reg,
  output logic            ex_branch,
  output logic [1:0]      forward_a,
  output logic [1:0]      forward_b,
  output logic            load_use_hazard,
  output logic [31:0]     bubble_count,
  output logic [31:0]     stall_count
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RA_W-1:0] rs1;
    logic [RA_W-1:0] rs2;
    logic [RA_W-1:0] rd;
    logic [2:0]      alu_control;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            branch;
  } ex_reg_t;

  ex_reg_t ex_q, ex_d;
  logic    load_bubble;

  assign load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                           ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2)) && id_valid;

  // A bubble is the all-zero register image; flush beats stall, a hazard only acts when not stalled.
  assign load_bubble = flush || (!stall && load_use_hazard);

  always_comb begin
    // NOTE: default to hold first so every path assigns ex_d and no latch is inferred.
    ex_d = ex_q;
    if (load_bubble) begin
      ex_d = '0;
    end else if (!stall) begin
      ex_d.valid       = id_valid;
      ex_d.pc          = id_pc;
      ex_d.rs1_data    = id_rs1_data;
      ex_d.rs2_data    = id_rs2_data;
      ex_d.imm         = id_imm;
      ex_d.rs1         = id_rs1;
      ex_d.rs2         = id_rs2;
      ex_d.rd          = id_rd;
      ex_d.alu_control = id_alu_control;
      ex_d.alu_src     = id_alu_src;
      ex_d.reg_write   = id_reg_write;
      ex_d.mem_read    = id_mem_read;
      ex_d.mem_write   = id_mem_write;
      ex_d.mem_to_reg  = id_mem_to_reg;
      ex_d.branch      = id_branch;
    end
  end

  // NOTE: reset is synchronous and active-high, so it lives inside the clocked branch.
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  // EX/MEM holds the newer value, so it is checked first; x0 never forwards.
  always_comb begin
    forward_a = 2'b00;
    forward_b = 2'b00;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_q.rs1))   forward_a = 2'b10;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_q.rs1)) forward_a = 2'b01;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == ex_q.rs2))   forward_b = 2'b10;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == ex_q.rs2)) forward_b = 2'b01;
  end

  always_comb begin
    case (forward_a)
      2'b10:   alu_a = mem_result;
      2'b01:   alu_a = wb_result;
      default: alu_a = ex_q.rs1_data;
    endcase
    case (forward_b)
      2'b10:   ex_store_data = mem_result;
      2'b01:   ex_store_data = wb_result;
      default: ex_store_data = ex_q.rs2_data;
    endcase
    alu_b = ex_q.alu_src ? ex_q.imm : ex_store_data;
  end

  assign ex_valid       = ex_q.valid;
  assign ex_pc          = ex_q.pc;
  assign ex_alu_control = ex_q.alu_control;
  assign ex_rd          = ex_q.rd;
  assign ex_reg_write   = ex_q.reg_write;
  assign ex_mem_read    = ex_q.mem_read;
  assign ex_mem_write   = ex_q.mem_write;
  assign ex_mem_to_reg  = ex_q.mem_to_reg;
  assign ex_branch      = ex_q.branch;

`ifdef IDEX_PERF_CNT_EN
  logic [31:0] bubble_count_q, bubble_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  // Both counters saturate rather than wrap.
  always_comb begin
    bubble_count_d = bubble_count_q;
    stall_count_d  = stall_count_q;
    if (stall && (stall_count_q != '1))
      stall_count_d = stall_count_q + 32'd1;
    if (!stall && (flush || load_use_hazard) && (bubble_count_q != '1))
      bubble_count_d = bubble_count_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count_q <= '0;
      stall_count_q  <= '0;
    end else begin
      bubble_count_q <= bubble_count_d;
      stall_count_q  <= stall_count_d;
    end
  end

  assign bubble_count = bubble_count_q;
  assign stall_count  = stall_count_q;
`else
  assign bubble_count = '0;
  assign stall_count  = '0;
`endif

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the 5-stage 64-bit pipeline. Registers decoded operands and control from ID, and resolves EX/MEM and MEM/WB forwarding into the final ALU operands.
- Detects load-use hazards and inserts bubbles.
- Sits directly upstream of the ALU, which receives already-forwarded a/b.

Parameters:
XLEN, 64, datapath width
RA_W, 5, register-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  external hold (e.g. memory wait); freezes register
flush  in  1  branch/exception kill; loads bubble
id_valid  in  1  ID holds a real instruction
id_pc  in  XLEN  instruction PC
id_rs1_data, id_rs2_data  in  XLEN  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_rs1, id_rs2, id_rd  in  RA_W  register addresses
id_alu_control  in  3  ALU opcode (ALU_ADD/SUB/AND/OR encodings)
id_alu_src  in  1  1 = operand b from immediate
id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg, id_branch  in  1 each  control
exm_reg_write  in  1  EX/MEM writes rd
exm_rd  in  RA_W  EX/MEM destination
mem_result  in  XLEN  EX/MEM forwarding value
wb_reg_write  in  1  MEM/WB writes rd
wb_rd  in  RA_W  MEM/WB destination
wb_result  in  XLEN  MEM/WB forwarding value
ex_valid  out  1  EX holds a real instruction
ex_pc  out  XLEN  registered PC
alu_a, alu_b  out  XLEN  forwarded ALU operands
ex_alu_control  out  3  registered opcode
ex_store_data  out  XLEN  forwarded rs2 for stores
ex_rd  out  RA_W  registered destination
ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg, ex_branch  out  1 each
forward_a, forward_b  out  2  select codes (observability)
load_use_hazard  out  1  upstream must stall IF/ID this cycle
bubble_count, stall_count  out  32  perf counters (see feature)

Behaviour:
- Register update priority at posedge clk: rst > flush > stall > load_use_hazard > normal load.
- rst: all ex_* control bits and ex_valid = 0. ex_pc, data, imm, rs/rd fields and ex_alu_control = 0. Counters = 0.
- flush: bubble. ex_valid and all five control bits = 0, data fields zeroed. Flush wins over stall in the same cycle.
- stall (no flush): every register holds. load_use_hazard still evaluated on the held state.
- load_use_hazard: combinational; = ex_valid & ex_mem_read & ex_rd != 0 & (ex_rd == id_rs1 | ex_rd == id_rs2) & id_valid.
  - When hazard, stall = 0 and flush = 0: register loads a bubble, same as flush. The ID instruction is re-presented next cycle by the stalled upstream.
- Normal load: all id_* fields captured; ex_valid = id_valid.
- Latency: one cycle ID to EX. alu_a/alu_b are combinational from registered state plus forwarding inputs.
- forward_a, computed from ex_rs1:
  - 2'b10 if exm_reg_write & exm_rd != 0 & exm_rd == ex_rs1;
  - else 2'b01 if wb_reg_write & wb_rd != 0 & wb_rd == ex_rs1;
  - else 2'b00.
  - EX/MEM has priority (newest value).
- forward_b: same rule using ex_rs2.
- Forwarded values: fwd_rs1 = mux(forward_a: 00 → ex_rs1_data, 10 → mem_result, 01 → wb_result). fwd_rs2 likewise; code 11 is unreachable and yields the register value.
- alu_a = fwd_rs1. alu_b = ex_alu_src ? ex_imm : fwd_rs2. ex_store_data = fwd_rs2 always.
- x0: address 0 is never forwarded; no hazard raised for rd = 0.
- Forwarding is computed regardless of ex_valid; downstream ignores results when ex_valid = 0.

Optional Feature:
- Macro IDEX_PERF_CNT_EN.
- Defined:
  - stall_count increments each cycle stall = 1 (not rst).
  - bubble_count increments each cycle a bubble is loaded (flush or load-use) and stall = 0.
  - Both saturate at 32'hFFFF_FFFF; cleared by rst.
- Undefined: both outputs tied to 0, no counter flops.

Test Plan:
- Reset then load ADD rs1=x1 (5), rs2=x2 (7), rd=x3 → next cycle ex_valid=1, alu_a=5, alu_b=7, forward_a=forward_b=00.
- EX/MEM rd=x1 mem_result=100 and MEM/WB rd=x1 wb_result=200, ex_rs1=x1 → forward_a=10, alu_a=100. With exm_rd=0 instead → forward_a=01, alu_a=200.
- EX holds load rd=x5, ID rs2=x5 → load_use_hazard=1, next cycle ex_valid=0 and controls 0, bubble_count +1 (feature on). With rd=x0 → no hazard.
- stall=1 for 3 cycles with id_* changing → all ex_* outputs held, stall_count=3. stall=1 & flush=1 together → bubble loaded.
- id_alu_src=1, imm=64'hFFFF_FFFF_FFFF_FFF0, rs2 forwarded from wb_result=9 → alu_b=imm, ex_store_data=9.
- Assert rst mid-stream with valid store in EX → next cycle ex_valid=0, ex_mem_write=0, counters=0.
